// File: rtl/param_ram.sv
// param_ram: single-port word RAM with a per-bit write mask, one-cycle
// registered reads, out-of-range error reporting and a self-clearing
// sequence that runs after reset or on request.

module param_ram #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 8,
    parameter int                 DEPTH     = 2**ADDR_W,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic              clr,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
);

    // CLEAR walks the array writing CLEAR_VAL; RUN serves accesses.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable for the range test.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              accept;
    logic              in_range;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign accept   = req & ready;
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign clr_last = (clr_cnt == LAST_IDX);

    // State register; reset always lands in CLEAR so the array gets initialised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a clr arriving on the final clear word restarts the walk.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: begin
                if (!clr && clr_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // Handshake outputs decode straight from the state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            ST_RUN:   ready = 1'b1;
            ST_CLEAR: busy  = 1'b1;
            default:  busy  = 1'b1;
        endcase
    end

    // Clear counter: reloads on clr in either state, advances one word per CLEAR cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (clr) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_last) begin
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
        end
    end

    // Array writes: clear walk in CLEAR, masked writes in RUN; no direct reset of contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= CLEAR_VAL;
            end else if (accept && we && in_range) begin
                mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
            end
        end
    end

    // Read/response pipeline; rdata only moves on an accepted read and holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= accept & ~we;
            err    <= accept & ~in_range;
            if (accept && !we) begin
                rdata <= in_range ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: directed, table-driven bench for param_ram with a default
// 256-word instance and a 200-word instance for out-of-range behaviour.

module tb_param_ram;

    logic        clk = 1'b0;

    // Default-parameter instance
    logic        rst_n, req, we, clr;
    logic [7:0]  addr;
    logic [15:0] wdata, wmask;
    logic        ready, busy, rvalid, err;
    logic [15:0] rdata;

    // DEPTH=200 instance
    logic        rst_n_s, req_s, we_s, clr_s;
    logic [7:0]  addr_s;
    logic [15:0] wdata_s, wmask_s;
    logic        ready_s, busy_s, rvalid_s, err_s;
    logic [15:0] rdata_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] wmask;
        logic        exp_rvalid;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    param_ram u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .wmask  (wmask),
        .clr    (clr),
        .ready  (ready),
        .busy   (busy),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    param_ram #(.DEPTH(200)) u_dut_s (
        .clk    (clk),
        .rst_n  (rst_n_s),
        .req    (req_s),
        .we     (we_s),
        .addr   (addr_s),
        .wdata  (wdata_s),
        .wmask  (wmask_s),
        .clr    (clr_s),
        .ready  (ready_s),
        .busy   (busy_s),
        .rdata  (rdata_s),
        .rvalid (rvalid_s),
        .err    (err_s)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Drive one cycle on the default instance starting at a negedge; returns at the next negedge
    task automatic applyStimulus(input logic r, input logic w, input logic c,
                                 input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
        req = r; we = w; clr = c; addr = a; wdata = d; wmask = m;
        @(negedge clk);
        req = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    // Same for the DEPTH=200 instance
    task automatic applyStimulusSmall(input logic r, input logic w,
                                      input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
        req_s = r; we_s = w; addr_s = a; wdata_s = d; wmask_s = m;
        @(negedge clk);
        req_s = 1'b0; we_s = 1'b0;
    endtask

    // Count negedges until the default instance leaves CLEAR (bounded)
    task automatic waitReady(output int cycles);
        cycles = 0;
        while (busy && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int main_at;
        int small_at;
        int cycles;
        int pulses;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; wdata = '0; wmask = '0;
        rst_n_s = 1'b0; req_s = 1'b0; we_s = 1'b0; clr_s = 1'b0; addr_s = '0; wdata_s = '0; wmask_s = '0;

        vecs[0]  = '{1'b1, 1'b1, 8'd5,   16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h13EC};
        vecs[1]  = '{1'b1, 1'b1, 8'd5,   16'h0000, 16'h00F0, 1'b0, 1'b0, 16'h13EC};
        vecs[2]  = '{1'b1, 1'b0, 8'd5,   16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFF0F};
        vecs[3]  = '{1'b0, 1'b0, 8'd9,   16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFF0F};
        vecs[4]  = '{1'b1, 1'b1, 8'd7,   16'hA5A5, 16'hFFFF, 1'b0, 1'b0, 16'hFF0F};
        vecs[5]  = '{1'b1, 1'b0, 8'd7,   16'h0000, 16'h0000, 1'b1, 1'b0, 16'hA5A5};
        vecs[6]  = '{1'b1, 1'b1, 8'd7,   16'h0F0F, 16'hFF00, 1'b0, 1'b0, 16'hA5A5};
        vecs[7]  = '{1'b1, 1'b0, 8'd7,   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0FA5};
        vecs[8]  = '{1'b1, 1'b0, 8'd6,   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0078};
        vecs[9]  = '{1'b1, 1'b0, 8'd5,   16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFF0F};
        vecs[10] = '{1'b1, 1'b1, 8'd255, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'hFF0F};
        vecs[11] = '{1'b1, 1'b0, 8'd255, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h13EC};
        vecs[12] = '{1'b1, 1'b0, 8'd0,   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000};

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",   32'(busy),   32'd1);
        checkOutput("rst_ready",  32'(ready),  32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_err",    32'(err),    32'd0);
        checkOutput("rst_rdata",  32'(rdata),  32'd0);
        checkOutput("rst_busy_s", 32'(busy_s), 32'd1);

        // Release reset and time both clear sequences
        rst_n = 1'b1; rst_n_s = 1'b1;
        main_at = 0; small_at = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (ready_s && small_at == 0) small_at = cyc;
            if (ready) begin
                main_at = cyc;
                break;
            end
        end
        checkOutput("clear_len",   32'(main_at),  32'd256);
        checkOutput("clear_len_s", 32'(small_at), 32'd200);

        // Every word reads back as the clear value
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(k), 16'h0, 16'h0);
            checkOutput($sformatf("clr_rd%0d", k), {14'd0, rvalid, err, rdata}, {14'd0, 1'b1, 1'b0, 16'h0000});
        end

        // Fill with k*20, then stream the reads back-to-back
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'(k), 16'(k * 20), 16'hFFFF);
            checkOutput($sformatf("wr%0d_resp", k), {30'd0, rvalid, err}, 32'd0);
        end
        pulses = 0;
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(k), 16'h0, 16'h0);
            if (rvalid) pulses++;
            checkOutput($sformatf("rd%0d", k), {15'd0, err, rdata}, {15'd0, 1'b0, 16'(k * 20)});
        end
        checkOutput("rd_pulses", 32'(pulses), 32'd256);

        // Table: masked writes, read-after-write, idle hold
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].req, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            checkOutput($sformatf("vec%0d", i), {14'd0, rvalid, err, rdata},
                        {14'd0, vecs[i].exp_rvalid, vecs[i].exp_err, vecs[i].exp_rdata});
        end

        // DEPTH=200: out-of-range reads and writes
        applyStimulusSmall(1'b1, 1'b1, 8'd199, 16'h7777, 16'hFFFF);
        checkOutput("s_wr199", {14'd0, rvalid_s, err_s, rdata_s}, {14'd0, 1'b0, 1'b0, 16'h0000});
        applyStimulusSmall(1'b1, 1'b0, 8'd199, 16'h0, 16'h0);
        checkOutput("s_rd199", {14'd0, rvalid_s, err_s, rdata_s}, {14'd0, 1'b1, 1'b0, 16'h7777});
        applyStimulusSmall(1'b1, 1'b0, 8'd200, 16'h0, 16'h0);
        checkOutput("s_rd200", {14'd0, rvalid_s, err_s, rdata_s}, {14'd0, 1'b1, 1'b1, 16'h0000});
        applyStimulusSmall(1'b0, 1'b0, 8'd0, 16'h0, 16'h0);
        checkOutput("s_idle", {30'd0, rvalid_s, err_s}, 32'd0);
        applyStimulusSmall(1'b1, 1'b1, 8'd250, 16'h1234, 16'hFFFF);
        checkOutput("s_wr250", {30'd0, rvalid_s, err_s}, {30'd0, 1'b0, 1'b1});
        applyStimulusSmall(1'b1, 1'b0, 8'd50, 16'h0, 16'h0);
        checkOutput("s_rd50", {14'd0, rvalid_s, err_s, rdata_s}, {14'd0, 1'b1, 1'b0, 16'h0000});
        applyStimulusSmall(1'b1, 1'b0, 8'd255, 16'h0, 16'h0);
        checkOutput("s_rd255", {14'd0, rvalid_s, err_s, rdata_s}, {14'd0, 1'b1, 1'b1, 16'h0000});

        // Reset in RUN overrides an out-of-range read presented with it
        rst_n_s = 1'b0;
        applyStimulusSmall(1'b1, 1'b0, 8'd210, 16'h0, 16'h0);
        checkOutput("s_rst_abort", {29'd0, busy_s, rvalid_s, err_s}, {29'd0, 1'b1, 1'b0, 1'b0});
        rst_n_s = 1'b1;

        // Read with clr in the same cycle still completes, then a full clear
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 16'hABCD, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 16'h0, 16'h0);
        checkOutput("clr_rd3", {13'd0, busy, rvalid, err, rdata}, {13'd0, 1'b1, 1'b1, 1'b0, 16'hABCD});
        waitReady(cycles);
        checkOutput("clr_len", 32'(cycles), 32'd256);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 16'h0, 16'h0);
        checkOutput("post_clr_rd3", {14'd0, rvalid, err, rdata}, {14'd0, 1'b1, 1'b0, 16'h0000});

        // clr during CLEAR restarts; requests are ignored while busy
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 16'h0, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd7, 16'h0, 16'h0);
        checkOutput("busy_req_ignored", {30'd0, busy, rvalid}, {30'd0, 1'b1, 1'b0});
        repeat (48) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 16'h0, 16'h0);
        waitReady(cycles);
        checkOutput("clr_restart_len", 32'(cycles), 32'd256);

        // Reset pulse at clear cycle 100 restarts the walk
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 16'h0, 16'h0);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst", {29'd0, busy, ready, rvalid}, {29'd0, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;
        waitReady(cycles);
        checkOutput("rst_restart_len", 32'(cycles), 32'd256);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd100, 16'h0, 16'h0);
        checkOutput("final_rd100", {14'd0, rvalid, err, rdata}, {14'd0, 1'b1, 1'b0, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits, at least 1.
REQ-002 Parameter ADDR_W, default 8: address width in bits, at least 1.
REQ-003 Parameter DEPTH, default 2**ADDR_W: number of implemented words, from 1 to 2**ADDR_W.
REQ-004 Parameter CLEAR_VAL, default 0: DATA_W-bit value written to every word during clear.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req  input  1  access request, qualified by ready.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 addr  input  ADDR_W  word address.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 wmask  input  DATA_W  per-bit write enable; 1 = update that bit.
REQ-012 clr  input  1  one-cycle request to re-clear the whole array.
REQ-013 ready  output  1  block can accept an access this cycle.
REQ-014 busy  output  1  clear sequence in progress.
REQ-015 rdata  output  DATA_W  registered read data.
REQ-016 rvalid  output  1  one-cycle pulse; rdata is valid.
REQ-017 err  output  1  one-cycle pulse; the accepted access was out of range.

Function
REQ-018 An access is accepted on a rising edge where req=1 and ready=1; at most one access per cycle.
REQ-019 FSM has two states: CLEAR (busy=1, ready=0) and RUN (busy=0, ready=1); ready and busy decode directly from state.
REQ-020 CLEAR: an internal counter starts at 0, and each cycle CLEAR_VAL is written to word counter, then counter increments by 1.
REQ-021 CLEAR -> RUN on the edge that writes word DEPTH-1; CLEAR therefore lasts exactly DEPTH cycles.
REQ-022 RUN -> CLEAR on an edge with clr=1, and the counter reloads to 0.
REQ-023 An access presented in the same cycle as clr is still accepted and completes; the clear starts on the next cycle.
REQ-024 clr while in CLEAR restarts the counter at 0.
REQ-025 Accepted write with addr<DEPTH: bit i of word addr takes wdata[i] where wmask[i]=1; bits with wmask[i]=0 keep their value.
REQ-026 Accepted read with addr<DEPTH: rdata is loaded with word addr and rvalid=1 on the following cycle, giving 1-cycle latency.
REQ-027 Accepted read with addr>=DEPTH: rdata is loaded with 0, rvalid=1 and err=1 on the following cycle.
REQ-028 Accepted write with addr>=DEPTH: the array is unchanged, err=1 on the following cycle, rvalid stays 0.
REQ-029 Reads on consecutive cycles give rvalid on consecutive cycles; back-to-back throughput is one access per cycle.
REQ-030 A read on the cycle immediately after a write to the same address returns the newly written data.
REQ-031 rdata holds its last value when rvalid=0.
REQ-032 When req=0, or no access is accepted, the next cycle has rvalid=0 and err=0.

Reset
REQ-033 On an edge with rst_n=0 the block sets: state=CLEAR, counter=0, ready=0, busy=1, rvalid=0, err=0, rdata=0.
REQ-034 Array contents are not reset directly; the clear sequence initialises them over DEPTH cycles after rst_n rises.
REQ-035 rst_n=0 during CLEAR restarts the clear at word 0.
REQ-036 rst_n=0 during RUN aborts any read in flight: no rvalid pulse and no err pulse follow.
REQ-037 rst_n dominates clr and req.

Verification
REQ-038 Default parameters: rst_n low for 2 cycles, then high -> busy=1 for exactly 256 cycles, then ready=1; reading addresses 0..255 returns 0 each time.
REQ-039 Default parameters: write k*20 (mod 2**16) to address k for k=0..255 with wmask=16'hFFFF, then read each address -> rdata=k*20 one cycle after each read, rvalid pulsed 256 times back-to-back.
REQ-040 Write 16'hFFFF to address 5, then write 16'h0000 with wmask=16'h00F0, then read address 5 -> rdata=16'hFF0F.
REQ-041 With DEPTH=200: read address 200 -> rdata=0, rvalid=1, err=1; write 16'h1234 to address 250 -> err=1, and address 250-200 aliasing is absent (read address 50 is unchanged).
REQ-042 Write 16'hABCD to address 3, pulse clr together with a read of address 3 -> rdata=16'hABCD and rvalid=1, then busy=1 for 256 cycles; a read of address 3 afterwards returns 0.
REQ-043 Assert rst_n=0 for one cycle at clear cycle 100 -> clear restarts, and ready rises 256 cycles after rst_n returns high.
